// File: rtl/crc_checker_pkg.sv
// Shared definitions for the serial CRC generator/checker pair: FSM encoding and
// default LFSR seed and tap mask.
package crc_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRxData,
    StRxCrc
  } state_e;

  localparam int unsigned DefLfsrWd = 8;
  localparam logic [7:0]  DefSeed   = 8'b1101_1000;
  localparam logic [7:0]  DefTaps   = 8'b0100_0100;

endpackage

// File: rtl/crc_checker_if.sv
// Serial frame bus: the sender drives qualified bits, the checker returns status and payload.
interface crc_checker_if #(
  parameter int unsigned DATA_WD = 8
);

  logic               ACTIVE;
  logic               DATA;
  logic               BUSY;
  logic               DONE;
  logic               CRC_OK;
  logic [DATA_WD-1:0] DATA_OUT;

  modport master (
    output ACTIVE,
    output DATA,
    input  BUSY,
    input  DONE,
    input  CRC_OK,
    input  DATA_OUT
  );

  modport slave (
    input  ACTIVE,
    input  DATA,
    output BUSY,
    output DONE,
    output CRC_OK,
    output DATA_OUT
  );

endinterface

// File: rtl/crc_lfsr_step.sv
// One-bit Galois LFSR step: feedback is LFSR[0] ^ bit, shifted right and XORed into tap positions.
module crc_lfsr_step #(
  parameter int unsigned     Width = 8,
  parameter logic [Width-1:0] Taps = '0
) (
  input  logic [Width-1:0] lfsr_i,
  input  logic             bit_i,
  output logic [Width-1:0] lfsr_o
);

  logic fb;

  always_comb begin
    fb = lfsr_i[0] ^ bit_i;
    for (int unsigned i = 0; i < Width - 1; i++) begin
      lfsr_o[i] = lfsr_i[i+1] ^ (Taps[i] & fb);
    end
    // Top bit takes the feedback directly; Taps[Width-1] has no effect.
    lfsr_o[Width-1] = fb;
  end

endmodule

// File: rtl/crc_checker.sv
// Serial CRC checker: accumulates DATA_WD payload bits into an LFSR, then compares the
// following LFSR_WD received bits against the LFSR contents and reports a verdict.
module crc_checker
  import crc_checker_pkg::*;
#(
  parameter int unsigned        LFSR_WD = DefLfsrWd,
  parameter int unsigned        DATA_WD = 8,
  parameter logic [LFSR_WD-1:0] SEED    = LFSR_WD'(DefSeed),
  parameter logic [LFSR_WD-1:0] TAPS    = LFSR_WD'(DefTaps)
) (
  input logic           CLK,
  input logic           RST,
  crc_checker_if.slave  bus
);

  localparam int unsigned FrameLen = DATA_WD + LFSR_WD;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  state_e             state_q, state_d;
  logic [LFSR_WD-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               crc_ok_q, crc_ok_d;
  logic [DATA_WD-1:0] data_out_q, data_out_d;
  logic               mismatch;

  crc_lfsr_step #(
    .Width (LFSR_WD),
    .Taps  (TAPS)
  ) u_lfsr_step (
    .lfsr_i (lfsr_q),
    .bit_i  (bus.DATA),
    .lfsr_o (lfsr_step)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    data_out_d = data_out_q;
    mismatch   = bus.DATA ^ lfsr_q[0];

    if (bus.ACTIVE) begin
      unique case (state_q)
        StIdle, StRxData: begin
          lfsr_d = lfsr_step;
          for (int unsigned i = 0; i < DATA_WD; i++) begin
            if (cnt_q == CntW'(i)) data_out_d[i] = bus.DATA;
          end
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CntW'(DATA_WD - 1)) ? StRxCrc : StRxData;
        end
        StRxCrc: begin
          if (cnt_q == CntW'(FrameLen - 1)) begin
            // Last CRC bit: verdict includes this bit's mismatch, ready for next frame.
            state_d  = StIdle;
            lfsr_d   = SEED;
            cnt_d    = '0;
            err_d    = 1'b0;
            done_d   = 1'b1;
            crc_ok_d = ~(err_q | mismatch);
          end else begin
            lfsr_d = lfsr_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            err_d  = err_q | mismatch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.BUSY     = (state_q != StIdle);
  assign bus.DONE     = done_q;
  assign bus.CRC_OK   = crc_ok_q;
  assign bus.DATA_OUT = data_out_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: good/bad frames, gaps, back-to-back frames and
// mid-frame reset, with hand-computed CRC values for SEED=8'hD8, TAPS=8'h44.
module tb_crc_checker;

  logic        clk;
  logic        rst_n;
  int unsigned cyc           = 0;
  int unsigned n_chk         = 0;
  int unsigned n_fail        = 0;
  int unsigned done_cnt      = 0;
  int unsigned done_cyc_last = 0;
  int unsigned done_cyc_prev = 0;

  crc_checker_if #(.DATA_WD(8)) bus ();

  crc_checker #(
    .LFSR_WD (8),
    .DATA_WD (8),
    .SEED    (8'hD8),
    .TAPS    (8'h44)
  ) u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc here equals the index of the edge that registered DONE.
  always @(negedge clk) begin
    if (bus.DONE === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      done_cyc_prev <= done_cyc_last;
      done_cyc_last <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ACTIVE = 1'b1;
    bus.DATA   = b;
    @(posedge clk);
    #1;
    bus.ACTIVE = 1'b0;
    bus.DATA   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pay, input logic [7:0] crc,
                            input int unsigned max_gap, output int unsigned first_cyc);
    first_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      logic        b;
      int unsigned ng;
      b  = (i < 8) ? pay[i] : crc[i-8];
      ng = (max_gap > 0 && i > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < int'(ng); g++) begin
        @(posedge clk);
        #1;
        check_eq("busy_gap", {31'b0, bus.BUSY}, 32'd1);
      end
      send_bit(b);
      if (i == 0) first_cyc = cyc;
      if (max_gap > 0 && i < 15) check_eq("busy_frame", {31'b0, bus.BUSY}, 32'd1);
    end
  endtask

  int unsigned f1, f2, cnt0;

  initial begin
    bus.ACTIVE = 1'b0;
    bus.DATA   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",     {31'b0, bus.BUSY},   32'd0);
    check_eq("rst_done",     {31'b0, bus.DONE},   32'd0);
    check_eq("rst_crc_ok",   {31'b0, bus.CRC_OK}, 32'd0);
    check_eq("rst_data_out", {24'b0, bus.DATA_OUT}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame: payload 00, CRC 14.
    send_frame(8'h00, 8'h14, 0, f1);
    check_eq("f1_done",     {31'b0, bus.DONE},   32'd1);
    check_eq("f1_crc_ok",   {31'b0, bus.CRC_OK}, 32'd1);
    check_eq("f1_data_out", {24'b0, bus.DATA_OUT}, 32'h00);
    check_eq("f1_busy",     {31'b0, bus.BUSY},   32'd0);
    @(negedge clk);
    #1;
    // 16 bits take edges f1..f1+15; DONE is valid in the cycle after edge f1+15.
    check_eq("f1_latency", done_cyc_last - f1, 32'd15);
    @(posedge clk);
    #1;
    check_eq("f1_done_pulse", {31'b0, bus.DONE},   32'd0);
    check_eq("f1_crc_hold",   {31'b0, bus.CRC_OK}, 32'd1);

    // Bad CRC.
    send_frame(8'h00, 8'h15, 0, f1);
    check_eq("f2_done",   {31'b0, bus.DONE},   32'd1);
    check_eq("f2_crc_ok", {31'b0, bus.CRC_OK}, 32'd0);
    @(posedge clk);
    #1;

    // Payload differs from the one the CRC was computed for.
    send_frame(8'h01, 8'h14, 0, f1);
    check_eq("f3_done",     {31'b0, bus.DONE},   32'd1);
    check_eq("f3_crc_ok",   {31'b0, bus.CRC_OK}, 32'd0);
    check_eq("f3_data_out", {24'b0, bus.DATA_OUT}, 32'h01);
    @(posedge clk);
    #1;

    // Good frame with random idle gaps.
    send_frame(8'h00, 8'h14, 3, f1);
    check_eq("f4_done",     {31'b0, bus.DONE},   32'd1);
    check_eq("f4_crc_ok",   {31'b0, bus.CRC_OK}, 32'd1);
    check_eq("f4_data_out", {24'b0, bus.DATA_OUT}, 32'h00);
    @(posedge clk);
    #1;

    // Back-to-back good then bad frame.
    send_frame(8'h00, 8'h14, 0, f1);
    check_eq("b2b1_done",   {31'b0, bus.DONE},   32'd1);
    check_eq("b2b1_crc_ok", {31'b0, bus.CRC_OK}, 32'd1);
    send_frame(8'h00, 8'h15, 0, f2);
    check_eq("b2b2_done",   {31'b0, bus.DONE},   32'd1);
    check_eq("b2b2_crc_ok", {31'b0, bus.CRC_OK}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("b2b_done_gap",  done_cyc_last - done_cyc_prev, 32'd16);
    check_eq("b2b_first_gap", f2 - f1, 32'd16);
    @(posedge clk);
    #1;

    // Abort after 5 payload bits with reset, then a full good frame.
    cnt0 = done_cnt;
    repeat (5) send_bit(1'b1);
    check_eq("abort_busy",     {31'b0, bus.BUSY},     32'd1);
    check_eq("abort_data_out", {24'b0, bus.DATA_OUT}, 32'h1F);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_rst_busy",     {31'b0, bus.BUSY},     32'd0);
    check_eq("abort_rst_data_out", {24'b0, bus.DATA_OUT}, 32'h00);
    check_eq("abort_rst_crc_ok",   {31'b0, bus.CRC_OK},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, cnt0);
    send_frame(8'h00, 8'h14, 0, f1);
    check_eq("post_rst_done",   {31'b0, bus.DONE},   32'd1);
    check_eq("post_rst_crc_ok", {31'b0, bus.CRC_OK}, 32'd1);
    @(negedge clk);
    #1;
    check_eq("post_rst_done_cnt", done_cnt, cnt0 + 1);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
